instr_loader: RTL and testbench

//  Boot-time program loader sitting upstream of the pipelined CPU's instruction memory.

---
 rtl/loader_pkg.sv | 23 ++
 rtl/instr_loader_if.sv | 28 ++
 rtl/instr_loader_word_assembler.sv | 35 +++
 rtl/instr_loader.sv | 155 +++++++++++++++
 tb/tb_instr_loader.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
// Optional feature macro: LOADER_CHECKSUM_EN (adds the CHK state).
package loader_pkg;

  typedef enum logic [2:0] {
    LEN   = 3'd0,
    DATA  = 3'd1,
    WRITE = 3'd2,
    CHK   = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } loader_state_t;

  localparam int          WORD_BYTES = 4;
  localparam int          LEN_BYTES  = 2;
  localparam logic [31:0] ADDR_STEP  = 32'd4;

  // Running XOR over the data bytes of one load.
  function automatic logic [7:0] checksum_update(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream input and imem write / CPU control output bundle of the loader.
// The loader uses the slave modport; the stream source / observer uses master.
interface instr_loader_if;

  logic        byte_valid_in;
  logic [7:0]  byte_in;
  logic        byte_ready_out;
  logic [31:0] instr_address_out;
  logic [31:0] instr_out;
  logic        instrWrite_out;
  logic        cpu_reset_out;
  logic        done_out;
  logic        error_out;
  logic [15:0] words_loaded_out;

  modport master (
    output byte_valid_in, byte_in,
    input  byte_ready_out, instr_address_out, instr_out, instrWrite_out,
    input  cpu_reset_out, done_out, error_out, words_loaded_out
  );

  modport slave (
    input  byte_valid_in, byte_in,
    output byte_ready_out, instr_address_out, instr_out, instrWrite_out,
    output cpu_reset_out, done_out, error_out, words_loaded_out
  );

endinterface

// File: rtl/instr_loader_word_assembler.sv
// Collects four stream bytes into a 32-bit word; byte order set by BIG_ENDIAN.
module word_assembler #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0]  idx_r;
  logic [31:0] word_r;

  assign word      = word_r;
  assign word_full = accept & (idx_r == 2'd3);

  // Byte index and word register; big-endian shifts in from the bottom.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx_r  <= 2'd0;
      word_r <= 32'd0;
    end else if (accept) begin
      idx_r <= idx_r + 2'd1;
      if (BIG_ENDIAN) begin
        word_r <= {word_r[23:0], byte_in};
      end else begin
        word_r[{idx_r, 3'b000} +: 8] <= byte_in;
      end
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Boot loader: length header, then words written to consecutive imem addresses;
// CPU held in reset until DONE. LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module instr_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
  parameter int          MAX_WORDS    = 1024,
  parameter bit          BIG_ENDIAN   = 1'b1
) (
  input  logic          clock_in,
  input  logic          reset_in,
  input  logic          start_in,
  instr_loader_if.slave bus
);

  localparam logic [31:0] MAX_WORDS_W = 32'(MAX_WORDS);
`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_t LAST_STATE = CHK;
`else
  localparam loader_state_t LAST_STATE = DONE;
`endif

  loader_state_t state_r, state_s;
  logic          ready_r, write_r, cpu_reset_r, done_r, error_r;
  logic          len_idx_r;
  logic [15:0]   count_r, words_r;
  logic [31:0]   addr_r;
  logic          accept_s, asm_accept_s, arm_s, word_full_s;
  logic [15:0]   len_full_s;
  logic [31:0]   word_s;

  assign accept_s     = bus.byte_valid_in & ready_r;
  assign asm_accept_s = accept_s & (state_r == DATA);

  word_assembler #(.BIG_ENDIAN(BIG_ENDIAN)) u_asm (
    .clk       (clock_in),
    .rst       (reset_in),
    .clr       (arm_s),
    .accept    (asm_accept_s),
    .byte_in   (bus.byte_in),
    .word      (word_s),
    .word_full (word_full_s)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] xor_r;

  // XOR of every data byte since the last arm.
  always_ff @(posedge clock_in) begin
    if (reset_in || arm_s) begin
      xor_r <= 8'd0;
    end else if (asm_accept_s) begin
      xor_r <= checksum_update(xor_r, bus.byte_in);
    end
  end
`endif

  // Next-state logic.
  always_comb begin
    state_s    = state_r;
    arm_s      = 1'b0;
    len_full_s = {count_r[15:8], bus.byte_in};
    case (state_r)
      LEN: begin
        if (accept_s && len_idx_r) begin
          if (len_full_s == 16'd0) begin
            state_s = LAST_STATE;
          end else if ({16'd0, len_full_s} > MAX_WORDS_W) begin
            state_s = ERROR;
          end else begin
            state_s = DATA;
          end
        end else begin
          state_s = LEN;
        end
      end
      DATA: begin
        if (word_full_s) state_s = WRITE;
        else             state_s = DATA;
      end
      WRITE: begin
        if (words_r + 16'd1 == count_r) state_s = LAST_STATE;
        else                            state_s = DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (accept_s) begin
          if (xor_r == bus.byte_in) state_s = DONE;
          else                      state_s = ERROR;
        end else begin
          state_s = CHK;
        end
      end
`endif
      DONE, ERROR: begin
        if (start_in) begin
          state_s = LEN;
          arm_s   = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = ERROR;
    endcase
  end

  // State register with outputs decoded from the next state, so they align with it.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_r     <= LEN;
      ready_r     <= 1'b1;
      write_r     <= 1'b0;
      cpu_reset_r <= 1'b1;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      ready_r     <= (state_s == LEN) || (state_s == DATA) || (state_s == CHK);
      write_r     <= (state_s == WRITE);
      cpu_reset_r <= (state_s != DONE);
      done_r      <= (state_s == DONE);
      error_r     <= (state_s == ERROR);
    end
  end

  // Length header, write address and word counter.
  always_ff @(posedge clock_in) begin
    if (reset_in || arm_s) begin
      len_idx_r <= 1'b0;
      count_r   <= 16'd0;
      addr_r    <= BASE_ADDRESS;
      words_r   <= 16'd0;
    end else begin
      if (state_r == LEN && accept_s) begin
        len_idx_r <= ~len_idx_r;
        if (len_idx_r) count_r[7:0]  <= bus.byte_in;
        else           count_r[15:8] <= bus.byte_in;
      end
      if (state_r == WRITE) begin
        addr_r  <= addr_r + ADDR_STEP;
        words_r <= words_r + 16'd1;
      end
    end
  end

  assign bus.byte_ready_out    = ready_r;
  assign bus.instr_address_out = addr_r;
  assign bus.instr_out         = word_s;
  assign bus.instrWrite_out    = write_r;
  assign bus.cpu_reset_out     = cpu_reset_r;
  assign bus.done_out          = done_r;
  assign bus.error_out         = error_r;
  assign bus.words_loaded_out  = words_r;

endmodule

// File: tb/tb_instr_loader.sv
// Drives one byte stream into a big-endian and a little-endian loader and
// scoreboards every imem write of both against expected address/data queues.
module tb_instr_loader;

  localparam logic [31:0] BE_BASE = 32'h0000_0000;
  localparam logic [31:0] LE_BASE = 32'h0000_1000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] word;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  data = 8'd0;
  int          tests = 0;
  int          fails = 0;
  wr_t         q_be[$];
  wr_t         q_le[$];
  wr_t         e_be, e_le;
  logic [31:0] exp_off = 32'd0;
  logic [7:0]  exp_xor = 8'd0;

  instr_loader_if bus_be();
  instr_loader_if bus_le();

  assign bus_be.byte_valid_in = valid;
  assign bus_be.byte_in       = data;
  assign bus_le.byte_valid_in = valid;
  assign bus_le.byte_in       = data;

  instr_loader #(.BASE_ADDRESS(BE_BASE), .MAX_WORDS(1024), .BIG_ENDIAN(1'b1)) dut_be (
    .clock_in(clk), .reset_in(rst), .start_in(start), .bus(bus_be));
  instr_loader #(.BASE_ADDRESS(LE_BASE), .MAX_WORDS(1024), .BIG_ENDIAN(1'b0)) dut_le (
    .clock_in(clk), .reset_in(rst), .start_in(start), .bus(bus_le));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Scoreboard: each write pulse pops one expected entry per DUT.
  always @(negedge clk) begin
    if (bus_be.instrWrite_out === 1'b1) begin
      tests++;
      assert (q_be.size() > 0) else begin
        fails++;
        $error("FAIL be_unexpected_write observed addr=%h expected no write", bus_be.instr_address_out);
      end
      if (q_be.size() > 0) begin
        e_be = q_be.pop_front();
        chk("be_wr_addr", bus_be.instr_address_out, e_be.addr);
        chk("be_wr_data", bus_be.instr_out, e_be.word);
      end
    end
    if (bus_le.instrWrite_out === 1'b1) begin
      tests++;
      assert (q_le.size() > 0) else begin
        fails++;
        $error("FAIL le_unexpected_write observed addr=%h expected no write", bus_le.instr_address_out);
      end
      if (q_le.size() > 0) begin
        e_le = q_le.pop_front();
        chk("le_wr_addr", bus_le.instr_address_out, e_le.addr);
        chk("le_wr_data", bus_le.instr_out, e_le.word);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int   n;
    logic acc;
    valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    valid = 1'b1;
    data  = b;
    acc   = 1'b0;
    n     = 0;
    while (!acc && n < 64) begin
      acc = bus_be.byte_ready_out;
      @(posedge clk); #1;
      n++;
    end
    valid = 1'b0;
    chk("byte_accepted", 32'(acc), 32'd1);
  endtask

  task automatic send_header(input logic [15:0] cnt);
    send_byte(cnt[15:8], 0);
    send_byte(cnt[7:0], 0);
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    q_be.push_back({BE_BASE + exp_off, w});
    q_le.push_back({LE_BASE + exp_off, swap32(w)});
    exp_off = exp_off + 32'd4;
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[i*8 +: 8], $urandom_range(max_gap, 0));
      exp_xor = exp_xor ^ w[i*8 +: 8];
    end
    chk("write_latency", 32'(bus_be.instrWrite_out), 32'd1);
  endtask

  task automatic wait_flag(input bit want_err);
    for (int i = 0; i < 20; i++) begin
      if ((want_err ? bus_be.error_out : bus_be.done_out) === 1'b1) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic finish_ok(input logic [15:0] words);
`ifdef LOADER_CHECKSUM_EN
    send_byte(exp_xor, 0);
`endif
    wait_flag(1'b0);
    chk("done",         32'(bus_be.done_out),      32'd1);
    chk("cpu_released", 32'(bus_be.cpu_reset_out), 32'd0);
    chk("no_error",     32'(bus_be.error_out),     32'd0);
    chk("be_words",     32'(bus_be.words_loaded_out), 32'(words));
    chk("le_done",      32'(bus_le.done_out),      32'd1);
    chk("le_words",     32'(bus_le.words_loaded_out), 32'(words));
    chk("be_q_empty",   32'(q_be.size()), 32'd0);
    chk("le_q_empty",   32'(q_le.size()), 32'd0);
  endtask

  task automatic arm();
    start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    exp_off = 32'd0;
    exp_xor = 8'd0;
    chk("arm_done_clr",  32'(bus_be.done_out),      32'd0);
    chk("arm_err_clr",   32'(bus_be.error_out),     32'd0);
    chk("arm_cpu_reset", 32'(bus_be.cpu_reset_out), 32'd1);
    chk("arm_ready",     32'(bus_be.byte_ready_out), 32'd1);
    chk("arm_words",     32'(bus_be.words_loaded_out), 32'd0);
    chk("arm_addr",      bus_be.instr_address_out,  BE_BASE);
  endtask

  task automatic check_reset_values();
    chk("rst_ready",     32'(bus_be.byte_ready_out), 32'd1);
    chk("rst_write",     32'(bus_be.instrWrite_out), 32'd0);
    chk("rst_instr",     bus_be.instr_out,           32'd0);
    chk("rst_addr_be",   bus_be.instr_address_out,   BE_BASE);
    chk("rst_addr_le",   bus_le.instr_address_out,   LE_BASE);
    chk("rst_cpu_reset", 32'(bus_be.cpu_reset_out),  32'd1);
    chk("rst_done",      32'(bus_be.done_out),       32'd0);
    chk("rst_error",     32'(bus_be.error_out),      32'd0);
    chk("rst_words",     32'(bus_be.words_loaded_out), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    rst = 1'b0;

    // Two words, back-to-back bytes held valid across WRITE.
    send_header(16'd2);
    send_word(32'h1122_3344, 0);
    send_word(32'h5566_7788, 0);
    finish_ok(16'd2);

    // Bytes offered in DONE are not consumed.
    valid = 1'b1;
    data  = 8'hAA;
    repeat (3) begin @(posedge clk); #1; end
    valid = 1'b0;
    chk("done_ignores_ready", 32'(bus_be.byte_ready_out), 32'd0);
    chk("done_ignores_words", 32'(bus_be.words_loaded_out), 32'd2);

    // Empty load.
    arm();
    send_header(16'd0);
    finish_ok(16'd0);

    // Oversize header, then recovery.
    arm();
    send_header(16'h0401);
    wait_flag(1'b1);
    chk("err_flag",      32'(bus_be.error_out),     32'd1);
    chk("err_cpu_reset", 32'(bus_be.cpu_reset_out), 32'd1);
    chk("err_not_done",  32'(bus_be.done_out),      32'd0);
    arm();
    send_header(16'd1);
    send_word(32'hDEAD_BEEF, 0);
    finish_ok(16'd1);

    // Randomly gapped stream.
    arm();
    send_header(16'd3);
    for (int k = 0; k < 3; k++) send_word($urandom, 3);
    finish_ok(16'd3);

    // Reset mid-load, then full resend.
    arm();
    send_header(16'd2);
    send_word(32'h1122_3344, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_values();
    rst     = 1'b0;
    exp_off = 32'd0;
    exp_xor = 8'd0;
    send_header(16'd2);
    send_word(32'h1122_3344, 0);
    send_word(32'h5566_7788, 0);
    finish_ok(16'd2);

`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum byte aborts the load.
    arm();
    send_header(16'd2);
    send_word(32'h1122_3344, 0);
    send_word(32'h5566_7788, 0);
    send_byte(8'h00, 0);
    wait_flag(1'b1);
    chk("chk_mismatch_err", 32'(bus_be.error_out), 32'd1);
    chk("chk_mismatch_cpu", 32'(bus_be.cpu_reset_out), 32'd1);
`endif

    repeat (2) begin @(posedge clk); #1; end
    chk("final_be_q_empty", 32'(q_be.size()), 32'd0);
    chk("final_le_q_empty", 32'(q_le.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
